// File: rtl/baud_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | baud_pkg                                                             |
// | Rate codes, baud constants and the elaboration-time divisor function.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package baud_pkg;

  localparam int unsigned FRAC_W = 8;

  localparam logic [2:0] c_sel_9600   = 3'd0;
  localparam logic [2:0] c_sel_19200  = 3'd1;
  localparam logic [2:0] c_sel_38400  = 3'd2;
  localparam logic [2:0] c_sel_57600  = 3'd3;
  localparam logic [2:0] c_sel_115200 = 3'd4;
  localparam logic [2:0] c_sel_230400 = 3'd5;
  localparam logic [2:0] c_sel_460800 = 3'd6;
  localparam logic [2:0] c_sel_custom = 3'd7;

  localparam int unsigned c_baud_9600   = 9600;
  localparam int unsigned c_baud_19200  = 19200;
  localparam int unsigned c_baud_38400  = 38400;
  localparam int unsigned c_baud_57600  = 57600;
  localparam int unsigned c_baud_115200 = 115200;
  localparam int unsigned c_baud_230400 = 230400;
  localparam int unsigned c_baud_460800 = 460800;

  function automatic int unsigned baud_of_sel(input logic [2:0] sel);
    case (sel)
      c_sel_19200:  return c_baud_19200;
      c_sel_38400:  return c_baud_38400;
      c_sel_57600:  return c_baud_57600;
      c_sel_115200: return c_baud_115200;
      c_sel_230400: return c_baud_230400;
      c_sel_460800: return c_baud_460800;
      default:      return c_baud_9600;
    endcase
  endfunction

  // CLK_HZ / (baud * oversample) as fixed point with FRAC_W fraction bits, truncated.
  function automatic logic [63:0] calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    logic [63:0] num;
    logic [63:0] den;
    num = {32'd0, clk_hz} << FRAC_W;
    den = {32'd0, baud} * {32'd0, os};
    return num / den;
  endfunction

endpackage
`default_nettype wire

// File: rtl/baud_frac_div.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | baud_frac_div                                                        |
// | Main interval counter (plus optional fractional accumulator when     |
// | BAUD_TICK_GEN_FRAC_EN is defined); produces the oversample tick.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module baud_frac_div
  import baud_pkg::*;
#(
  parameter int unsigned DIV_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic                    i_clr,
  input  logic [DIV_W+FRAC_W-1:0] i_div,
  output logic                    o_wrap,
  output logic                    o_rx_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_last;
  logic             w_extra;
  logic             r_rx_tick;

`ifdef BAUD_TICK_GEN_FRAC_EN
  logic [FRAC_W-1:0] r_acc;
  logic              r_extra;
  logic [FRAC_W:0]   w_acc_sum;

  assign w_acc_sum = {1'b0, r_acc} + {1'b0, i_div[FRAC_W-1:0]};
  assign w_extra   = r_extra;

  // Carry out of the accumulator stretches the following interval by one cycle.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_acc   <= '0;
      r_extra <= 1'b0;
    end else if (o_wrap) begin
      r_acc   <= w_acc_sum[FRAC_W-1:0];
      r_extra <= w_acc_sum[FRAC_W];
    end
  end
`else
  logic w_unused_frac;
  assign w_unused_frac = ^i_div[FRAC_W-1:0];
  assign w_extra       = 1'b0;
`endif

  assign w_last = i_div[DIV_W+FRAC_W-1:FRAC_W] - DIV_W'(1) + {{(DIV_W-1){1'b0}}, w_extra};
  assign o_wrap = i_en && (r_cnt == w_last);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt     <= '0;
      r_rx_tick <= 1'b0;
    end else begin
      r_rx_tick <= o_wrap;
      if (i_en) begin
        r_cnt <= o_wrap ? '0 : r_cnt + DIV_W'(1);
      end
    end
  end

  assign o_rx_tick = r_rx_tick;

endmodule
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | baud_tick_gen                                                        |
// | Oversample/bit tick generator with rate table, custom divisor and    |
// | glitch-free rate switching. Macro: BAUD_TICK_GEN_FRAC_EN.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [2:0]              select,
  input  logic [DIV_W+FRAC_W-1:0] custom_div,
  output logic                    rx_tick,
  output logic                    tx_tick,
  output logic                    baud_clk,
  output logic                    rate_ack
);

  localparam int unsigned          c_dw       = DIV_W + FRAC_W;
  localparam int unsigned          c_sub_w    = $clog2(OVERSAMPLE);
  localparam logic [c_sub_w-1:0]   c_sub_mid  = c_sub_w'(OVERSAMPLE / 2 - 1);
  localparam logic [c_sub_w-1:0]   c_sub_last = c_sub_w'(OVERSAMPLE - 1);
  localparam logic [c_dw-1:0]      c_min_div  = c_dw'(2) << FRAC_W;

  logic [c_dw-1:0]    w_tab [8];
  logic [c_dw-1:0]    r_pend;
  logic [c_dw-1:0]    r_act;
  logic [c_sub_w-1:0] r_sub;
  logic               r_tx_tick;
  logic               r_baud_clk;
  logic               r_rate_ack;
  logic               w_wrap;
  logic               w_load;

  // Fixed-rate divisors, clamped to 2.0 at elaboration.
  for (genvar gi = 0; gi < 7; gi++) begin : g_tab
    localparam logic [63:0] c_raw = calc_div(CLK_HZ, baud_of_sel(3'(gi)), OVERSAMPLE);
    assign w_tab[gi] = (c_raw[c_dw-1:FRAC_W] < DIV_W'(2)) ? c_min_div : c_raw[c_dw-1:0];
  end

  assign w_tab[7] = (custom_div[c_dw-1:FRAC_W] < DIV_W'(2)) ? c_min_div : custom_div;

  // A running link only switches rate right after a bit boundary; an idle one switches at once.
  assign w_load = (r_pend != r_act) && (!en || r_tx_tick);

  baud_frac_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .i_en      (en),
    .i_clr     (w_load),
    .i_div     (r_act),
    .o_wrap    (w_wrap),
    .o_rx_tick (rx_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend     <= w_tab[0];
      r_act      <= w_tab[0];
      r_sub      <= '0;
      r_tx_tick  <= 1'b0;
      r_baud_clk <= 1'b0;
      r_rate_ack <= 1'b0;
    end else begin
      r_pend     <= w_tab[select];
      r_rate_ack <= w_load;
      if (w_load) begin
        r_act      <= r_pend;
        r_sub      <= '0;
        r_tx_tick  <= 1'b0;
        r_baud_clk <= 1'b0;
      end else begin
        r_tx_tick <= w_wrap && (r_sub == c_sub_last);
        if (w_wrap) begin
          r_sub <= r_sub + c_sub_w'(1);
          if ((r_sub == c_sub_mid) || (r_sub == c_sub_last)) begin
            r_baud_clk <= ~r_baud_clk;
          end
        end
      end
    end
  end

  assign tx_tick  = r_tx_tick;
  assign baud_clk = r_baud_clk;
  assign rate_ack = r_rate_ack;

endmodule
`default_nettype wire

// File: tb/tb_baud_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_baud_tick_gen                                                     |
// | Scoreboard bench: expected tick/ack cycles queued, monitor compares. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_baud_tick_gen;

  localparam int unsigned DIV_W = 24;
`ifdef BAUD_TICK_GEN_FRAC_EN
  localparam int c_frac_9600 = 10;
  localparam int c_frac_115k = 64;
`else
  localparam int c_frac_9600 = 0;
  localparam int c_frac_115k = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en  = 1'b0;
  logic [2:0]        select = 3'b000;
  logic [DIV_W+7:0]  custom_div = '0;
  logic              rx_tick;
  logic              tx_tick;
  logic              baud_clk;
  logic              rate_ack;

  baud_tick_gen #(
    .CLK_HZ     (100000000),
    .OVERSAMPLE (16),
    .DIV_W      (DIV_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .select     (select),
    .custom_div (custom_div),
    .rx_tick    (rx_tick),
    .tx_tick    (tx_tick),
    .baud_clk   (baud_clk),
    .rate_ack   (rate_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int   t;
    logic bclk;
  } rx_exp_t;

  rx_exp_t q_rx[$];
  int      q_tx[$];
  int      q_ack[$];

  int   m_t, m_acc, m_extra, m_sub, m_floor, m_frac;
  logic m_bclk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented pulse is matched against the next queued expectation.
  always @(negedge clk) begin
    rx_exp_t e;
    if (rx_tick) begin
      if (q_rx.size() == 0) check("rx_tick unexpected", int'(rx_tick), 0);
      else begin
        e = q_rx.pop_front();
        check("rx_tick cycle", cyc, e.t);
        check("baud_clk at rx_tick", int'(baud_clk), int'(e.bclk));
      end
    end
    if (tx_tick) begin
      if (q_tx.size() == 0) check("tx_tick unexpected", int'(tx_tick), 0);
      else check("tx_tick cycle", cyc, q_tx.pop_front());
    end
    if (rate_ack) begin
      if (q_ack.size() == 0) check("rate_ack unexpected", int'(rate_ack), 0);
      else check("rate_ack cycle", cyc, q_ack.pop_front());
    end
  end

  task automatic model_load(input int t, input int fl, input int fr);
    m_t = t; m_acc = 0; m_extra = 0; m_sub = 0; m_bclk = 1'b0;
    m_floor = fl; m_frac = fr;
  endtask

  task automatic push_ticks(input int n, input int stall);
    rx_exp_t e;
    for (int k = 0; k < n; k++) begin
      m_t += m_floor + m_extra + ((k == 0) ? stall : 0);
      m_sub = (m_sub + 1) % 16;
      if (m_sub == 8 || m_sub == 0) m_bclk = ~m_bclk;
      e.t = m_t;
      e.bclk = m_bclk;
      q_rx.push_back(e);
      if (m_sub == 0) q_tx.push_back(m_t);
      m_acc += m_frac;
      m_extra = (m_acc >= 256) ? 1 : 0;
      m_acc = m_acc % 256;
    end
  endtask

  task automatic step_to(input int t);
    while (cyc < t) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    check({name, " leftover rx"}, q_rx.size(), 0);
    check({name, " leftover tx"}, q_tx.size(), 0);
    check({name, " leftover ack"}, q_ack.size(), 0);
    q_rx.delete();
    q_tx.delete();
    q_ack.delete();
  endtask

  task automatic check_idle(input string name);
    check({name, " rx_tick"}, int'(rx_tick), 0);
    check({name, " tx_tick"}, int'(tx_tick), 0);
    check({name, " baud_clk"}, int'(baud_clk), 0);
    check({name, " rate_ack"}, int'(rate_ack), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, c, l, p;

    // Reset state, then 9600 from release; a select glitch that reverts must not load.
    rst = 1'b1; en = 1'b0; select = 3'b000; custom_div = '0;
    step_to(4);
    check_idle("reset");
    r = cyc;
    rst = 1'b0; en = 1'b1;
    model_load(r, 651, c_frac_9600);
    push_ticks(16, 0);
    step_to(r + 1000); select = 3'b100;
    step_to(r + 1005); select = 3'b000;
    step_to(m_t); en = 1'b0;
    drain("9600");

    // Idle switch to 115200 loads after one cycle of pending.
    c = cyc; select = 3'b100;
    q_ack.push_back(c + 2);
    step_to(c + 2); en = 1'b1;
    model_load(c + 2, 54, c_frac_115k);
    push_ticks(32, 0);
    p = m_t;
    // en dropped for 100 cycles mid-count: next tick is delayed by exactly that much.
    push_ticks(3, 100);
    step_to(p + 20);  en = 1'b0;
    step_to(p + 120); en = 1'b1;
    step_to(m_t); en = 1'b0;
    drain("115200 with stall");

    // Custom divisor 0 clamps to 2; change to 115200 mid-bit waits for the bit boundary.
    c = cyc; select = 3'b111; custom_div = '0;
    q_ack.push_back(c + 2);
    step_to(c + 2); en = 1'b1;
    model_load(c + 2, 2, 0);
    push_ticks(20, 0);
    step_to(m_t); select = 3'b100;
    push_ticks(12, 0);
    l = m_t + 1;
    q_ack.push_back(l);
    step_to(l);
    model_load(l, 54, c_frac_115k);
    push_ticks(8, 0);
    step_to(m_t); en = 1'b0;
    drain("custom to 115200");

    // One-cycle reset mid-bit with a pending change: idle outputs, 9600 active, no ack.
    c = cyc; en = 1'b1; select = 3'b000;
    step_to(c + 10); rst = 1'b1;
    step_to(c + 11);
    check_idle("mid-bit reset");
    rst = 1'b0;
    model_load(c + 11, 651, c_frac_9600);
    push_ticks(2, 0);
    step_to(m_t); en = 1'b0;
    step_to(m_t + 5);
    drain("after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
